// File: rtl/alu_issue_if.sv
// Producer-side instruction handshake for the ALU issue stage.
interface alu_issue_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_opcode;
  logic [3:0] in_a;
  logic [3:0] in_b;

  modport master (output in_valid, output in_opcode, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_opcode, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/alu_issue.sv
// Instruction FIFO feeding a registered 4-bit ALU: issues one entry per cycle,
// guards divide-by-zero and delays the issue strobe to line up with the ALU result.
module alu_issue #(
  parameter int DEPTH = 4,  // power of two, >= 2
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  alu_issue_if.slave       in_if,
  input  logic             hold,
  output logic [3:0]       op1,
  output logic [3:0]       op2,
  output logic [1:0]       opcode,
  output logic             issue_valid,
  output logic             res_valid,
  output logic             res_dz,
  output logic [CNT_W-1:0] issued_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = DEPTH[AW:0];

  logic [9:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_occ;
  logic [3:0]       r_op1;
  logic [3:0]       r_op2;
  logic [1:0]       r_opcode;
  logic             r_issue;
  logic             r_dz;
  logic             r_res_valid;
  logic             r_res_dz;
  logic [CNT_W-1:0] r_count;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [9:0] w_head;
  logic       w_dz;

  always_comb begin
    w_full  = (r_occ == OCC_FULL);
    w_empty = (r_occ == '0);
    // in_ready looks only at registered occupancy, never at a same-edge pop
    w_push  = in_if.in_valid && !w_full;
    w_pop   = !w_empty && !hold;
    w_head  = r_mem[r_rptr];
    w_dz    = (w_head[9:8] == 2'd3) && (w_head[3:0] == 4'd0);
  end

  assign in_if.in_ready = !w_full;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= {in_if.in_opcode, in_if.in_b, in_if.in_a};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_occ       <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_opcode    <= '0;
      r_issue     <= 1'b0;
      r_dz        <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_dz    <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr   <= r_rptr + AW'(1);
        r_op1    <= w_dz ? 4'd1 : w_head[3:0];
        r_op2    <= w_head[7:4];
        r_opcode <= w_head[9:8];
        r_count  <= r_count + CNT_W'(1);
      end
      r_issue     <= w_pop;
      r_dz        <= w_pop && w_dz;
      r_res_valid <= r_issue;
      r_res_dz    <= r_dz;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (AW+1)'(1);
        2'b01:   r_occ <= r_occ - (AW+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign op1          = r_op1;
  assign op2          = r_op2;
  assign opcode       = r_opcode;
  assign issue_valid  = r_issue;
  assign res_valid    = r_res_valid;
  assign res_dz       = r_res_dz;
  assign issued_count = r_count;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue (DEPTH=4, CNT_W=3) with hand-computed expectations.
module tb_alu_issue;
  logic       clock;
  logic       reset_n;
  logic       hold;
  logic [3:0] op1;
  logic [3:0] op2;
  logic [1:0] opcode;
  logic       issue_valid;
  logic       res_valid;
  logic       res_dz;
  logic [2:0] issued_count;

  int total = 0;
  int bad   = 0;

  alu_issue_if u_if ();

  alu_issue #(.DEPTH(4), .CNT_W(3)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_if       (u_if),
    .hold        (hold),
    .op1         (op1),
    .op2         (op2),
    .opcode      (opcode),
    .issue_valid (issue_valid),
    .res_valid   (res_valid),
    .res_dz      (res_dz),
    .issued_count(issued_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    u_if.in_valid  = 1'b1;
    u_if.in_opcode = op;
    u_if.in_a      = a;
    u_if.in_b      = b;
  endtask

  initial begin
    reset_n = 1'b0;
    hold = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_opcode = '0;
    u_if.in_a = '0;
    u_if.in_b = '0;
    #12;
    chk("rst_issue", 32'(issue_valid), 32'd0);
    chk("rst_res", 32'(res_valid), 32'd0);
    chk("rst_op1", 32'(op1), 32'd0);
    chk("rst_count", 32'(issued_count), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", 32'(u_if.in_ready), 32'd1);
    tick();

    // single add: 3 + 5
    offer(2'd0, 4'd3, 4'd5);
    tick();
    u_if.in_valid = 1'b0;
    chk("nobypass", 32'(issue_valid), 32'd0);
    tick();
    chk("add_issue", 32'(issue_valid), 32'd1);
    chk("add_op1", 32'(op1), 32'd3);
    chk("add_op2", 32'(op2), 32'd5);
    chk("add_opc", 32'(opcode), 32'd0);
    chk("add_res_early", 32'(res_valid), 32'd0);
    chk("add_count", 32'(issued_count), 32'd1);
    tick();
    chk("add_res", 32'(res_valid), 32'd1);
    chk("add_dz", 32'(res_dz), 32'd0);
    chk("add_issue_off", 32'(issue_valid), 32'd0);
    chk("add_op1_keep", 32'(op1), 32'd3);

    // divide by zero guard, then a normal divide
    offer(2'd3, 4'd0, 4'd9);
    tick();
    u_if.in_valid = 1'b0;
    tick();
    chk("dz_op1", 32'(op1), 32'd1);
    chk("dz_op2", 32'(op2), 32'd9);
    chk("dz_opc", 32'(opcode), 32'd3);
    tick();
    chk("dz_res", 32'(res_valid), 32'd1);
    chk("dz_flag", 32'(res_dz), 32'd1);
    offer(2'd3, 4'd2, 4'd9);
    tick();
    u_if.in_valid = 1'b0;
    tick();
    chk("div_op1", 32'(op1), 32'd2);
    tick();
    chk("div_res", 32'(res_valid), 32'd1);
    chk("div_flag", 32'(res_dz), 32'd0);
    chk("div_count", 32'(issued_count), 32'd3);

    // fill under hold, refuse a fifth, then drain in order
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("fill_ready", 32'(u_if.in_ready), 32'd1);
      offer(2'd0, 4'(i), 4'(i + 4));
      tick();
    end
    chk("full_ready", 32'(u_if.in_ready), 32'd0);
    offer(2'd0, 4'd15, 4'd15);
    tick();
    u_if.in_valid = 1'b0;
    chk("full_ready2", 32'(u_if.in_ready), 32'd0);
    chk("hold_noissue", 32'(issue_valid), 32'd0);
    hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_issue", 32'(issue_valid), 32'd1);
      chk("drain_op1", 32'(op1), 32'(i));
      chk("drain_op2", 32'(op2), 32'(i + 4));
      chk("drain_ready", 32'(u_if.in_ready), 32'd1);
    end
    chk("drain_count", 32'(issued_count), 32'd7);
    tick();
    chk("drain_last_res", 32'(res_valid), 32'd1);
    chk("drain_done", 32'(issue_valid), 32'd0);
    tick();
    chk("fifth_dropped", 32'(issue_valid), 32'd0);
    chk("drain_res_off", 32'(res_valid), 32'd0);

    // async reset with 3 queued and a result in flight
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(2'd1, 4'(i), 4'd8);
      tick();
    end
    u_if.in_valid = 1'b0;
    hold = 1'b0;
    tick();
    chk("pre_rst_issue", 32'(issue_valid), 32'd1);
    chk("wrap_count", 32'(issued_count), 32'd0);
    hold = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_issue", 32'(issue_valid), 32'd0);
    chk("arst_op1", 32'(op1), 32'd0);
    chk("arst_opc", 32'(opcode), 32'd0);
    chk("arst_ready", 32'(u_if.in_ready), 32'd1);
    #2;
    reset_n = 1'b1;
    hold = 1'b0;
    tick();
    chk("arst_res", 32'(res_valid), 32'd0);
    chk("arst_empty", 32'(issue_valid), 32'd0);
    tick();
    chk("arst_res2", 32'(res_valid), 32'd0);
    chk("arst_cnt", 32'(issued_count), 32'd0);

    // continuous stream of 10 adds
    for (int i = 0; i < 10; i++) begin
      offer(2'd0, 4'(i), 4'(i + 1));
      tick();
      if (i > 0) begin
        chk("strm_issue", 32'(issue_valid), 32'd1);
        chk("strm_op1", 32'(op1), 32'(i - 1));
        chk("strm_count", 32'(issued_count), 32'(i % 8));
      end
      if (i > 1) chk("strm_res", 32'(res_valid), 32'd1);
    end
    u_if.in_valid = 1'b0;
    tick();
    chk("strm_last_op1", 32'(op1), 32'd9);
    chk("strm_final_cnt", 32'(issued_count), 32'd2);
    chk("strm_res_l", 32'(res_valid), 32'd1);
    tick();
    chk("strm_res_end", 32'(res_valid), 32'd1);
    tick();
    chk("strm_res_off", 32'(res_valid), 32'd0);

    // hold for two cycles mid-stream
    hold = 1'b1;
    for (int i = 7; i <= 9; i++) begin
      offer(2'd1, 4'(i), 4'd1);
      tick();
    end
    u_if.in_valid = 1'b0;
    hold = 1'b0;
    tick();
    chk("mh_op1_a", 32'(op1), 32'd7);
    tick();
    chk("mh_op1_b", 32'(op1), 32'd8);
    chk("mh_res_a", 32'(res_valid), 32'd1);
    hold = 1'b1;
    tick();
    chk("mh_iss_off1", 32'(issue_valid), 32'd0);
    chk("mh_inflight", 32'(res_valid), 32'd1);
    chk("mh_stable1", 32'(op1), 32'd8);
    tick();
    chk("mh_iss_off2", 32'(issue_valid), 32'd0);
    chk("mh_res_off1", 32'(res_valid), 32'd0);
    chk("mh_stable2", 32'(op1), 32'd8);
    hold = 1'b0;
    tick();
    chk("mh_issue_c", 32'(issue_valid), 32'd1);
    chk("mh_op1_c", 32'(op1), 32'd9);
    chk("mh_res_off2", 32'(res_valid), 32'd0);
    tick();
    chk("mh_res_c", 32'(res_valid), 32'd1);
    chk("mh_count", 32'(issued_count), 32'd5);
    tick();
    chk("mh_no_dup", 32'(res_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
